seri_toplayici_kontrol: RTL and testbench

SERI_TOPLAYICI_KONTROL -- requirements
Module: seri_toplayici_kontrol

---
 rtl/seri_toplayici_kontrol.sv | 125 ++++++++++++
 tb/tb_seri_toplayici_kontrol.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/seri_toplayici_kontrol.sv
// Serial adder: one 4-bit adder slice reused over NIBBLES cycles to form {cout,sum} = a + b + cin.
// Optional macro SUBTRACT_EN adds an op port selecting a - b (cout = 1 means no borrow).
module seri_toplayici_kontrol #(
    parameter  int NIBBLES = 4,
    localparam int W       = 4 * NIBBLES
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SUBTRACT_EN
    input  logic         op,
`endif
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         busy,
    output logic         done,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(NIBBLES);
    localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

    // Handshake: start is taken only in IDLE; done is a single-cycle pulse and
    // sum/cout are valid while done=1 and stay stable until the next accepted start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   a_r, b_r;
    logic           carry_r;
    logic [CW-1:0]  cnt;
    logic [3:0]     slice_a, slice_b, slice_s;
    logic           slice_c;

    assign slice_a = a_r[{cnt, 2'b00} +: 4];
`ifdef SUBTRACT_EN
    logic op_r;
    assign slice_b = op_r ? ~b_r[{cnt, 2'b00} +: 4] : b_r[{cnt, 2'b00} +: 4];
`else
    assign slice_b = b_r[{cnt, 2'b00} +: 4];
`endif

    toplayici4bit u_add (
        .A   (slice_a),
        .B   (slice_b),
        .Cin (carry_r),
        .S   (slice_s),
        .Cout(slice_c)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (cnt == LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r     <= '0;
            b_r     <= '0;
            carry_r <= 1'b0;
            cnt     <= '0;
            sum     <= '0;
            cout    <= 1'b0;
`ifdef SUBTRACT_EN
            op_r    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_r <= a;
                        b_r <= b;
                        cnt <= '0;
`ifdef SUBTRACT_EN
                        op_r    <= op;
                        // Two's complement subtract: invert b slices and seed carry with 1.
                        carry_r <= op ? 1'b1 : cin;
`else
                        carry_r <= cin;
`endif
                    end
                end
                RUN: begin
                    sum[{cnt, 2'b00} +: 4] <= slice_s;
                    carry_r                <= slice_c;
                    cnt                    <= cnt + CW'(1);
                    if (cnt == LAST) cout <= slice_c;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state_q == RUN) || (state_q == DONE);
    assign done      = (state_q == DONE);
    assign state_dbg = state_q;

endmodule

// 4-bit ripple slice shared across all nibbles of the operation.
module toplayici4bit (
    input  logic [3:0] A,
    input  logic [3:0] B,
    input  logic       Cin,
    output logic [3:0] S,
    output logic       Cout
);
    assign {Cout, S} = {1'b0, A} + {1'b0, B} + {4'b0000, Cin};
endmodule

// File: tb/tb_seri_toplayici_kontrol.sv
// Directed bench for seri_toplayici_kontrol: vector table plus hand-written multi-cycle sequences.
module tb_seri_toplayici_kontrol;

    localparam int NIBBLES = 4;
    localparam int W       = 4 * NIBBLES;

    logic         clk = 1'b0;
    logic         rst, start, cin, op;
    logic [W-1:0] a, b;
    logic [W-1:0] sum;
    logic         cout, busy, done;
    logic [1:0]   state_dbg;

    int checks = 0;
    int errors = 0;
    logic [W:0] exp_q[$];

    seri_toplayici_kontrol #(.NIBBLES(NIBBLES)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef SUBTRACT_EN
        .op       (op),
`endif
        .sum      (sum),
        .cout     (cout),
        .busy     (busy),
        .done     (done),
        .state_dbg(state_dbg)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout act=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // driver: one operation, waits (bounded) for done and scores result, latency and busy length
    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         input logic top, input logic [W-1:0] esum, input logic ecout,
                         input string nm);
        int cyc;
        int busy_cnt;
        logic [W:0] e;
        exp_q.push_back({ecout, esum});
        @(negedge clk);
        a = ta; b = tb_v; cin = tcin; op = top; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        busy_cnt = 0;
        while (!done && cyc < 20) begin
            if (busy) busy_cnt++;
            cyc++;
            @(negedge clk);
        end
        if (busy) busy_cnt++;
        e = exp_q.pop_front();
        chk({nm, "_latency"}, cyc, NIBBLES);
        chk({nm, "_busy_cycles"}, busy_cnt, NIBBLES + 1);
        chk({nm, "_sum"}, sum, e[W-1:0]);
        chk({nm, "_cout"}, cout, e[W]);
    endtask

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int done_cnt;
        logic [W-1:0] ra, rb;
        logic rc;
        logic [W:0] model;

        vecs[0] = '{16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0};
        vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1};
        vecs[2] = '{16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0};
        vecs[3] = '{16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0};
        vecs[4] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
        vecs[5] = '{16'h0F0F, 16'hF0F0, 1'b1, 16'h0000, 1'b1};
        vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'hBE01, 1'b0};
        vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0; op = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_state", state_dbg, 0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout,
                  $sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_done_pulse", i), done, 0);
            chk($sformatf("vec%0d_idle_busy", i), busy, 0);
        end

        // random sums scored against a plain a+b+cin model
        for (int i = 0; i < 4; i++) begin
            ra = W'($urandom_range(0, 16'hFFFF));
            rb = W'($urandom_range(0, 16'hFFFF));
            rc = 1'($urandom_range(0, 1));
            model = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            do_op(ra, rb, rc, 1'b0, model[W-1:0], model[W], $sformatf("rnd%0d", i));
            @(negedge clk);
        end

        // back-to-back: second start in the first IDLE cycle after DONE
        do_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, "b2b_first");
        do_op(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, "b2b_second");
        @(negedge clk);

        // start during RUN is ignored; operand changes after capture do not matter
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        a = 16'hFFFF; b = 16'hFFFF; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        done_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) begin
                done_cnt++;
                chk("ignore_start_sum", sum, 16'h2345);
                chk("ignore_start_cout", cout, 0);
            end
            @(negedge clk);
        end
        chk("ignore_start_done_count", done_cnt, 1);

        // reset at the second RUN edge aborts the operation
        a = 16'h1234; b = 16'h1111; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_sum", sum, 0);
        chk("abort_cout", cout, 0);
        chk("abort_state", state_dbg, 0);
        done_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            if (done) done_cnt++;
            @(negedge clk);
        end
        chk("abort_no_done", done_cnt, 0);

`ifdef SUBTRACT_EN
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, "sub_borrow");
        @(negedge clk);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, "sub_noborrow");
        @(negedge clk);
        do_op(16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0, "sub_op0_add");
        @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
